// File: rtl/wb_cmd_exec.sv
// wb_cmd_exec: executes one host command word at a time as a single
// pipelined-Wishbone bus cycle (READ/WRITE) or as a local operation
// (SET_ADDR/CLEAR). Each result goes out as a 34-bit response word with a
// one-cycle valid pulse.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   i_cmd_stb           command strobe (edge-detected, may be held)
//   i_cmd_word[33:0]    [33:32] opcode, [31:0] payload
//   o_busy              acceptance through response cycle
//   o_cmd_drop          sticky: a command edge arrived while busy
//   o_wb_*              Wishbone master (cyc/stb/we/addr/data/sel)
//   i_wb_*              Wishbone slave responses (stall/ack/err/data)
//   o_rsp_stb           one-cycle response valid
//   o_rsp_word[33:0]    [33:32] response code, [31:0] data
module wb_cmd_exec #(
  parameter int AW      = 30,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cmd_stb,
  input  logic [33:0]   i_cmd_word,
  output logic          o_busy,
  output logic          o_cmd_drop,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [31:0]   o_wb_data,
  output logic [3:0]    o_wb_sel,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  input  logic [31:0]   i_wb_data,
  output logic          o_rsp_stb,
  output logic [33:0]   o_rsp_word
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SETA  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic            stb_prev_q, stb_prev_d;
  logic            busy_q, busy_d;
  logic            drop_q, drop_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            inc_q, inc_d;
  logic            we_q, we_d;
  logic [31:0]     data_q, data_d;
  logic [33:0]     rsp_q, rsp_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [1:0]      op;
  logic [31:0]     payload;
  logic            cmd_edge, accept, tmo_hit, can_finish;

  assign op       = i_cmd_word[33:32];
  assign payload  = i_cmd_word[31:0];
  assign cmd_edge = i_cmd_stb & ~stb_prev_q;
  assign accept   = cmd_edge & ~busy_q;
  // Counter reads TIMEOUT-1 on the last permitted cyc cycle.
  assign tmo_hit  = (cnt_q == CW'(TIMEOUT - 1));
  // In BUS a response only counts once the slave has taken the request.
  assign can_finish = (state_q == S_WAIT) || !i_wb_stall;

  always_comb begin
    state_d    = state_q;
    stb_prev_d = i_cmd_stb;
    drop_d     = drop_q;
    addr_d     = addr_q;
    inc_d      = inc_q;
    we_d       = we_q;
    data_d     = data_q;
    rsp_d      = rsp_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (op)
            OP_READ: begin
              state_d = S_BUS;
              we_d    = 1'b0;
              cnt_d   = '0;
            end
            OP_WRITE: begin
              state_d = S_BUS;
              we_d    = 1'b1;
              data_d  = payload;
              cnt_d   = '0;
            end
            OP_SETA: begin
              state_d = S_RESP;
              addr_d  = payload[AW+1:2];
              inc_d   = payload[0];
              rsp_d   = {2'b10, payload};
            end
            OP_CLEAR: drop_d = 1'b0;
            default: ;
          endcase
        end
      end
      S_BUS, S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (can_finish && i_wb_err) begin
          state_d = S_RESP;
          rsp_d   = {2'b11, 32'h0};
        end else if (can_finish && i_wb_ack) begin
          state_d = S_RESP;
          rsp_d   = we_q ? {2'b00, 32'h0} : {2'b01, i_wb_data};
          if (inc_q) addr_d = addr_q + AW'(1);
        end else if (tmo_hit) begin
          state_d = S_RESP;
          rsp_d   = {2'b11, 32'h1};
        end else if (state_q == S_BUS && !i_wb_stall) begin
          state_d = S_WAIT;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // An edge while busy is lost; set wins over a same-cycle clear.
    if (cmd_edge && busy_q) drop_d = 1'b1;

    // CLEAR never leaves IDLE but still shows one busy cycle.
    busy_d = (state_d != S_IDLE) || (accept && op == OP_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      stb_prev_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      addr_q     <= '0;
      inc_q      <= 1'b0;
      we_q       <= 1'b0;
      data_q     <= '0;
      rsp_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      stb_prev_q <= stb_prev_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      addr_q     <= addr_d;
      inc_q      <= inc_d;
      we_q       <= we_d;
      data_q     <= data_d;
      rsp_q      <= rsp_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_cmd_drop = drop_q;
  assign o_wb_cyc   = (state_q == S_BUS) || (state_q == S_WAIT);
  assign o_wb_stb   = (state_q == S_BUS);
  assign o_wb_we    = we_q & o_wb_cyc;
  assign o_wb_addr  = addr_q;
  assign o_wb_data  = data_q;
  assign o_wb_sel   = o_wb_stb ? 4'hF : 4'h0;
  assign o_rsp_stb  = (state_q == S_RESP);
  assign o_rsp_word = rsp_q;

endmodule

// File: doc/wb_cmd_exec.md
# wb_cmd_exec

Wishbone command executor that sits directly downstream of the host command-word generator. It consumes the 34-bit command word and its strobe, which come from host wire-ins or the automatic ADC read sequence. It runs single pipelined-Wishbone bus cycles against the SPI master and peripheral bus. Each result is returned as a 34-bit response word with a one-cycle valid pulse for the readback FIFO.

## Interface
Parameters:
- AW, 30, Wishbone word-address width (≤ 30)
- TIMEOUT, 1023, max cycles a bus cycle may stay open before being aborted (≥ 2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset. **One clock; reset is synchronous and active-high.**
- i_cmd_stb  in  1  command strobe; may be held high for several consecutive cycles per command
- i_cmd_word  in  34  command: [33:32] opcode, [31:0] payload
- o_busy  out  1  high from command acceptance until the response cycle, inclusive
- o_cmd_drop  out  1  sticky; set when a command is lost because the block was busy
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls
- o_wb_addr  out  AW  word address
- o_wb_data  out  32  write data
- o_wb_sel  out  4  byte selects; always 4'hF while o_wb_stb is high, else 0
- i_wb_stall, i_wb_ack, i_wb_err  in  1 each  slave responses
- i_wb_data  in  32  read data
- o_rsp_stb  out  1  one-cycle response valid
- o_rsp_word  out  34  response: [33:32] code, [31:0] data

## Operation
- Command acceptance is edge-based: a command is taken in a cycle where i_cmd_stb=1, the registered previous-cycle strobe is 0, and o_busy=0.
- A rising edge that arrives while o_busy=1 is discarded and sets o_cmd_drop.
- A strobe held high for N cycles issues exactly one command.
- Internal state: addr[AW-1:0] (reset 0) and inc (reset 0).
- Opcodes:
  - 2'b00 READ: Wishbone read at addr. On ack: response {2'b01, i_wb_data}. If inc=1, addr increments, modulo 2^AW (wraps to 0).
  - 2'b01 WRITE: Wishbone write of payload[31:0] to addr. On ack: response {2'b00, 32'h0}. Post-increment as for READ.
  - 2'b10 SET_ADDR: addr ← payload[AW+1:2], inc ← payload[0]; payload[1] is ignored. No bus cycle. Response {2'b10, payload}.
  - 2'b11 CLEAR: clears o_cmd_drop. No bus cycle, no response.
- FSM states:
  - IDLE: accept command. READ/WRITE → BUS. SET_ADDR → RESP. CLEAR stays in IDLE (o_busy pulses one cycle).
  - BUS: cyc=1, stb=1. Leave when i_wb_stall=0. Go to RESP if ack or err arrived in that same cycle, else WAIT.
  - WAIT: cyc=1, stb=0. On err → RESP with error. On ack → RESP.
  - RESP: o_rsp_stb=1 for exactly one cycle, cyc=0 → IDLE.
- Error and timeout:
  - Error response: {2'b11, 32'h0}.
  - Timeout: a counter starts at 0 when cyc rises and increments each cycle cyc=1. If it reaches TIMEOUT with no ack/err, cyc and stb drop and RESP issues {2'b11, 32'h1}.
  - On error or timeout, addr does not increment.
- ack and err in the same cycle: err wins.
- ack/err seen while cyc=0: ignored.

## Timing
- Reset values: every output is 0 (o_busy, o_cmd_drop, cyc/stb/we, addr, data, sel, o_rsp_stb, o_rsp_word). addr=0, inc=0, FSM=IDLE.
- A rst asserted mid-transaction drops cyc the next cycle with no response.
- Acceptance on cycle k: o_busy=1, o_wb_cyc=1, o_wb_stb=1 and addr/we/data valid from cycle k+1.
- o_wb_stb stays high, with all bus outputs stable, until the first cycle with i_wb_stall=0.
- Ack on cycle n: o_rsp_stb on cycle n+1. o_busy falls at n+2. Updated addr is visible at n+1.
- Zero-stall, ack on the cycle after stb: READ/WRITE latency from acceptance to o_rsp_stb is 3 cycles.
- SET_ADDR: o_rsp_stb at k+1; new addr visible at k+1.
- Earliest next acceptance is the cycle o_busy is 0 again. A strobe rising edge during RESP is dropped.
- o_cmd_drop sets the cycle after the offending edge. CLEAR clears it at k+1; set takes precedence over clear only if both happen in the same cycle (not possible while busy).

## Test plan
- Reset, then SET_ADDR 34'h2_0000_0001 with strobe held 2 cycles → one response {2'b10, 32'h1}, addr=0, inc=1, o_cmd_drop=0.
- Inc=1; two READs of slave returning 32'hA5A5_0001 then 32'hA5A5_0002, zero stall, 1-cycle ack → responses {2'b01, A5A50001} and {2'b01, A5A50002}; o_wb_addr 0 then 1.
- WRITE 34'h1_DEAD_BEEF with i_wb_stall high for 3 cycles → stb held 4 cycles with stable data, response {2'b00, 0}, we=1 during cycle.
- Slave never acks, TIMEOUT=16 → cyc drops 16 cycles after rising, response 34'h3_0000_0001, addr unchanged.
- ack and err asserted together → response 34'h3_0000_0000. Second rising strobe during WAIT → o_cmd_drop=1. CLEAR → o_cmd_drop=0.
- Set addr to 2^AW−1 with inc=1, then READ → addr wraps to 0. Assert rst mid-WAIT → cyc=0 next cycle, no o_rsp_stb.
